regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the next-generation RISC-V core. It has NUM_RD combinational read ports and NUM_WR write ports. Optional write-to-read bypass handles same-cycle forwarding. A per-register busy scoreboard tracks outstanding producers. The block replaces the fixed 2R1W register file and sits between decode (reads, allocations) and writeback (writes).

---
 rtl/regfile_mp.sv | 130 +++++++++++++
 tb/tb_regfile_mp.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file
// with write-to-read bypass and a per-register busy scoreboard.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_RD*ADDR_W-1:0]   i_rs_addr,
  output logic [NUM_RD*DATA_W-1:0]   o_rs_data,
  output logic [NUM_RD-1:0]          o_rs_busy,
  input  logic [NUM_WR-1:0]          i_rd_wren,
  input  logic [NUM_WR*ADDR_W-1:0]   i_rd_addr,
  input  logic [NUM_WR*DATA_W-1:0]   i_rd_data,
  input  logic                       i_alloc_en,
  input  logic [ADDR_W-1:0]          i_alloc_addr,
  output logic                       o_wr_conflict
);

  localparam int DEPTH = 1 << ADDR_W;

  function automatic logic writable(
    input logic [ADDR_W-1:0] a
  );
    return !(ZERO_REG != 0 && a == '0);
  endfunction

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] wr_val [DEPTH];
  logic [DEPTH-1:0]  wr_hit;
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic              conflict_d;
  logic              conflict_q;

  // merge write ports per register; higher ports override lower
  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < DEPTH; r++) begin
      wr_val[r] = '0;
    end
    for (int w = 0; w < NUM_WR; w++) begin
      if (i_rd_wren[w] &&
          writable(i_rd_addr[w*ADDR_W +: ADDR_W])) begin
        wr_hit[i_rd_addr[w*ADDR_W +: ADDR_W]] = 1'b1;
        wr_val[i_rd_addr[w*ADDR_W +: ADDR_W]] =
          i_rd_data[w*DATA_W +: DATA_W];
      end
    end
  end

  // writes retire producers; a same-cycle alloc supersedes them
  always_comb begin
    busy_d = busy_q & ~wr_hit;
    if (i_alloc_en && writable(i_alloc_addr)) begin
      busy_d[i_alloc_addr] = 1'b1;
    end
  end

  // flag any pair of enabled ports hitting the same live register
  always_comb begin
    conflict_d = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (i_rd_wren[i] && i_rd_wren[j] &&
            i_rd_addr[i*ADDR_W +: ADDR_W] ==
            i_rd_addr[j*ADDR_W +: ADDR_W] &&
            writable(i_rd_addr[i*ADDR_W +: ADDR_W])) begin
          conflict_d = 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              b;

    assign a = i_rs_addr[k*ADDR_W +: ADDR_W];

    // stored value, then same-cycle forward, then zero register
    always_comb begin
      d = regs_q[a];
      b = busy_q[a];
      if (BYPASS != 0) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (i_rd_wren[w] &&
              i_rd_addr[w*ADDR_W +: ADDR_W] == a) begin
            d = i_rd_data[w*DATA_W +: DATA_W];
            b = 1'b0;
          end
        end
      end
      if (!writable(a)) begin
        d = '0;
        b = 1'b0;
      end
    end

    assign o_rs_data[k*DATA_W +: DATA_W] = d;
    assign o_rs_busy[k] = b;
  end

  // register array, scoreboard and conflict flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
      end
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (wr_hit[r]) begin
          regs_q[r] <= wr_val[r];
        end
      end
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign o_wr_conflict = conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: random + directed check of regfile_mp against
// an array model, on default, no-bypass and 3R1W/64-bit builds.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  logic [4:0]  rs_addr [2];
  logic [1:0]  wren;
  logic [4:0]  wa [2];
  logic [31:0] wd [2];
  logic        alloc_en;
  logic [4:0]  alloc_addr;

  logic [63:0] a_data, b_data;
  logic [1:0]  a_busy, b_busy;
  logic        a_conf, b_conf;

  logic [3:0]  c_rs [3];
  logic [0:0]  c_wren;
  logic [3:0]  c_wa;
  logic [63:0] c_wd;
  logic        c_ae;
  logic [3:0]  c_aa;
  logic [191:0] c_data;
  logic [2:0]  c_busy;
  logic        c_conf;

  regfile_mp u_a (
    .i_clk(clk), .i_rst(rst),
    .i_rs_addr({rs_addr[1], rs_addr[0]}),
    .o_rs_data(a_data), .o_rs_busy(a_busy),
    .i_rd_wren(wren),
    .i_rd_addr({wa[1], wa[0]}),
    .i_rd_data({wd[1], wd[0]}),
    .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr),
    .o_wr_conflict(a_conf)
  );

  regfile_mp #(.BYPASS(0), .ZERO_REG(0)) u_b (
    .i_clk(clk), .i_rst(rst),
    .i_rs_addr({rs_addr[1], rs_addr[0]}),
    .o_rs_data(b_data), .o_rs_busy(b_busy),
    .i_rd_wren(wren),
    .i_rd_addr({wa[1], wa[0]}),
    .i_rd_data({wd[1], wd[0]}),
    .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr),
    .o_wr_conflict(b_conf)
  );

  regfile_mp #(
    .DATA_W(64), .ADDR_W(4), .NUM_RD(3), .NUM_WR(1)
  ) u_c (
    .i_clk(clk), .i_rst(rst),
    .i_rs_addr({c_rs[2], c_rs[1], c_rs[0]}),
    .o_rs_data(c_data), .o_rs_busy(c_busy),
    .i_rd_wren(c_wren), .i_rd_addr(c_wa), .i_rd_data(c_wd),
    .i_alloc_en(c_ae), .i_alloc_addr(c_aa),
    .o_wr_conflict(c_conf)
  );

  // model: m=0 is the bypass/zero-reg build, m=1 the plain one
  logic [31:0] mem [2][32];
  logic        bsy [2][32];
  logic        conf [2];
  logic [63:0] cmem [16];
  logic        cbsy [16];

  function automatic bit live(int m, logic [4:0] a);
    return !(m == 0 && a == 5'd0);
  endfunction

  function automatic logic conflict_of(int m);
    return wren[0] && wren[1] && wa[0] == wa[1] && live(m, wa[0]);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        for (int r = 0; r < 32; r++) begin
          mem[m][r] <= '0;
          bsy[m][r] <= 1'b0;
        end
        conf[m] <= 1'b0;
      end
      for (int r = 0; r < 16; r++) begin
        cmem[r] <= '0;
        cbsy[r] <= 1'b0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        conf[m] <= conflict_of(m);
        for (int w = 0; w < 2; w++) begin
          if (wren[w] && live(m, wa[w])) begin
            mem[m][wa[w]] <= wd[w];
            bsy[m][wa[w]] <= 1'b0;
          end
        end
        if (alloc_en && live(m, alloc_addr))
          bsy[m][alloc_addr] <= 1'b1;
      end
      if (c_wren[0] && c_wa != 4'd0) begin
        cmem[c_wa] <= c_wd;
        cbsy[c_wa] <= 1'b0;
      end
      if (c_ae && c_aa != 4'd0) cbsy[c_aa] <= 1'b1;
    end
  end

  function automatic logic [31:0] exp_data(int m, int k);
    logic [4:0] a = rs_addr[k];
    logic [31:0] d;
    if (!live(m, a)) return '0;
    d = mem[m][a];
    if (m == 0)
      for (int w = 0; w < 2; w++)
        if (wren[w] && wa[w] == a) d = wd[w];
    return d;
  endfunction

  function automatic logic exp_busy(int m, int k);
    logic [4:0] a = rs_addr[k];
    logic b;
    if (!live(m, a)) return 1'b0;
    b = bsy[m][a];
    if (m == 0)
      for (int w = 0; w < 2; w++)
        if (wren[w] && wa[w] == a) b = 1'b0;
    return b;
  endfunction

  function automatic logic [63:0] cexp_data(int k);
    if (c_rs[k] == 4'd0) return '0;
    if (c_wren[0] && c_wa == c_rs[k]) return c_wd;
    return cmem[c_rs[k]];
  endfunction

  function automatic logic cexp_busy(int k);
    if (c_rs[k] == 4'd0) return 1'b0;
    if (c_wren[0] && c_wa == c_rs[k]) return 1'b0;
    return cbsy[c_rs[k]];
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // compare every output against the model once per cycle
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("A rd%0d data", k),
            64'(a_data[k*32 +: 32]), 64'(exp_data(0, k)));
        chk($sformatf("A rd%0d busy", k),
            64'(a_busy[k]), 64'(exp_busy(0, k)));
        chk($sformatf("B rd%0d data", k),
            64'(b_data[k*32 +: 32]), 64'(exp_data(1, k)));
        chk($sformatf("B rd%0d busy", k),
            64'(b_busy[k]), 64'(exp_busy(1, k)));
      end
      chk("A conflict", 64'(a_conf), 64'(conf[0]));
      chk("B conflict", 64'(b_conf), 64'(conf[1]));
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("C rd%0d data", k),
            c_data[k*64 +: 64], cexp_data(k));
        chk($sformatf("C rd%0d busy", k),
            64'(c_busy[k]), 64'(cexp_busy(k)));
      end
      chk("C conflict", 64'(c_conf), 64'd0);
    end
  end

  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      rs_addr[i] = '0; wa[i] = '0; wd[i] = '0;
    end
    wren = '0; alloc_en = 1'b0; alloc_addr = '0;
    for (int i = 0; i < 3; i++) c_rs[i] = '0;
    c_wren = '0; c_wa = '0; c_wd = '0;
    c_ae = 1'b0; c_aa = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rnd();
    for (int i = 0; i < 2; i++) begin
      rs_addr[i] = 5'($urandom_range(0, 9));
      wa[i] = 5'($urandom_range(0, 9));
      wd[i] = $urandom;
    end
    wren = 2'($urandom);
    alloc_en = 1'($urandom);
    alloc_addr = 5'($urandom_range(0, 9));
    for (int i = 0; i < 3; i++) c_rs[i] = 4'($urandom);
    c_wren = 1'($urandom);
    c_wa = 4'($urandom);
    c_wd = {$urandom, $urandom};
    c_ae = 1'($urandom);
    c_aa = 4'($urandom);
  endtask

  initial begin
    idle();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset data", a_data, 64'd0);
    chk("reset busy", 64'(a_busy), 64'd0);
    chk("reset conflict", 64'(a_conf), 64'd0);
    cmp_on = 1'b1;

    step();
    wren[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'h1234_5678;
    rs_addr[1] = 5'd3;
    c_wren = 1'b1; c_wa = 4'd15;
    c_wd = 64'hA5A5_0123_4567_89AB;
    #1;
    chk("bypass same cycle", 64'(a_data[63:32]), 64'h1234_5678);
    chk("no bypass old", 64'(b_data[63:32]), 64'd0);

    step();
    rs_addr[1] = 5'd3;
    for (int i = 0; i < 3; i++) c_rs[i] = 4'd15;
    #1;
    chk("read after write A", 64'(a_data[63:32]), 64'h1234_5678);
    chk("read after write B", 64'(b_data[63:32]), 64'h1234_5678);
    for (int i = 0; i < 3; i++)
      chk($sformatf("C x15 rd%0d", i), c_data[i*64 +: 64],
          64'hA5A5_0123_4567_89AB);
    chk("C conflict zero", 64'(c_conf), 64'd0);

    step();
    wren = 2'b11; wd[0] = 32'hFFFF_FFFF; wd[1] = 32'hFFFF_FFFF;
    alloc_en = 1'b1;
    #1;
    chk("x0 data same cycle", 64'(a_data[31:0]), 64'd0);
    chk("x0 busy same cycle", 64'(a_busy[0]), 64'd0);

    step();
    #1;
    chk("x0 data", 64'(a_data[31:0]), 64'd0);
    chk("x0 busy", 64'(a_busy[0]), 64'd0);
    chk("x0 no conflict", 64'(a_conf), 64'd0);
    chk("B x0 conflict", 64'(b_conf), 64'd1);
    chk("B x0 data", 64'(b_data[31:0]), 64'hFFFF_FFFF);
    chk("B x0 alloc wins", 64'(b_busy[0]), 64'd1);

    step();
    wren = 2'b11; wa[0] = 5'd7; wa[1] = 5'd7;
    wd[0] = 32'h1; wd[1] = 32'h2; rs_addr[0] = 5'd7;
    #1;
    chk("collide bypass", 64'(a_data[31:0]), 64'h2);

    step();
    rs_addr[0] = 5'd7;
    #1;
    chk("collide stored", 64'(a_data[31:0]), 64'h2);
    chk("collide conflict", 64'(a_conf), 64'd1);

    step();
    #1;
    chk("conflict one cycle", 64'(a_conf), 64'd0);

    step();
    alloc_en = 1'b1; alloc_addr = 5'd9; rs_addr[0] = 5'd9;
    #1;
    chk("alloc not yet", 64'(a_busy[0]), 64'd0);

    step();
    rs_addr[0] = 5'd9; wren[0] = 1'b1; wa[0] = 5'd9;
    wd[0] = 32'hAA;
    #1;
    chk("alloc busy B", 64'(b_busy[0]), 64'd1);
    chk("write fwd busy A", 64'(a_busy[0]), 64'd0);

    step();
    rs_addr[0] = 5'd9;
    #1;
    chk("write clears busy", 64'(a_busy[0]), 64'd0);
    chk("x9 data", 64'(a_data[31:0]), 64'hAA);

    step();
    alloc_en = 1'b1; alloc_addr = 5'd9;
    wren[1] = 1'b1; wa[1] = 5'd9; wd[1] = 32'hBB;

    step();
    rs_addr[0] = 5'd9;
    #1;
    chk("alloc+write busy", 64'(a_busy[0]), 64'd1);
    chk("alloc+write data", 64'(a_data[31:0]), 64'hBB);

    step();
    wren[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'hDEAD_BEEF;
    alloc_en = 1'b1; alloc_addr = 5'd5;

    step();
    rs_addr[0] = 5'd5; rs_addr[1] = 5'd5;
    wren = 2'b11; wa[0] = 5'd6; wa[1] = 5'd6;
    wd[0] = 32'h1111_1111; wd[1] = 32'h2222_2222;
    alloc_en = 1'b1; alloc_addr = 5'd6;
    #1;
    chk("x5 before reset", 64'(a_data[31:0]), 64'hDEAD_BEEF);
    chk("x5 busy before", 64'(a_busy[0]), 64'd1);
    rst = 1'b1;
    #1;
    chk("x5 after reset", 64'(a_data[31:0]), 64'd0);
    chk("x5 busy after", 64'(a_busy[0]), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle();
    rs_addr[0] = 5'd6;
    #1;
    chk("discarded write", 64'(a_data[31:0]), 64'd0);
    chk("discarded alloc", 64'(a_busy[0]), 64'd0);
    chk("discarded conflict", 64'(a_conf), 64'd0);

    for (int n = 0; n < 3000; n++) begin
      step();
      rnd();
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end
    step();
    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
